dmem_responder: RTL and testbench

- Multi-cycle data-memory responder, 32 words x 32 bits, byte-addressed through a 7-bit address.
- Serves load/store requests from the CPU datapath (the initiator) over a valid/ready request channel and a valid/ready response channel.
- Stores perform byte, halfword or word lane merges. Loads return the full aligned word; the CPU does lane selection and extension.
- Inserts a configurable number of wait states to model slow memory for the upcoming stall-capable core.

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: 32-bit words, byte-addressed,
// valid/ready request and response channels, configurable wait states.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | req_ready high, waiting for a request
// WAIT  | request latched, counting down wait states before commit
// RESP  | response held on rsp_* until the initiator takes it
module dmem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT             state;
  logic [3:0]        waitCnt;
  logic              latWe;
  logic [1:0]        latSize;
  logic [ADDR_W-1:0] latAddr;
  logic [31:0]       latWdata;

  // Contents are deliberately left out of reset so a preload survives it.
  logic [31:0]       mem [DEPTH];

  logic              cWe;
  logic [1:0]        cSize;
  logic [ADDR_W-1:0] cAddr;
  logic [31:0]       cWdata;
  logic [IDX_W-1:0]  cIdx;
  logic [31:0]       oldWord;
  logic [31:0]       mergedWord;
  logic [31:0]       commitData;
  logic              cErr;
  logic              commitNow;

  // Select commit operands: live request when committing straight from IDLE
  // (zero wait states), otherwise the fields latched at acceptance.
  always_comb begin
    cWe    = latWe;
    cSize  = latSize;
    cAddr  = latAddr;
    cWdata = latWdata;
    if (state == IDLE) begin
      cWe    = req_we;
      cSize  = req_size;
      cAddr  = req_addr;
      cWdata = req_wdata;
    end
  end

  assign cIdx    = cAddr[ADDR_W-1:2];
  assign oldWord = mem[cIdx];

  // Alignment/size check and byte-lane merge of store data into the old word.
  always_comb begin
    cErr = (cSize == 2'b11)
         || ((cSize == 2'b01) && cAddr[0])
         || ((cSize == 2'b10) && (cAddr[1:0] != 2'b00));
    mergedWord = oldWord;
    case (cSize)
      2'b00:   mergedWord[{cAddr[1:0], 3'b000} +: 8] = cWdata[7:0];
      2'b01:   mergedWord[{cAddr[1], 4'b0000} +: 16] = cWdata[15:0];
      2'b10:   mergedWord = cWdata;
      default: mergedWord = oldWord;
    endcase
    if (cErr)     commitData = 32'h0;
    else if (cWe) commitData = mergedWord;
    else          commitData = oldWord;
  end

  assign commitNow = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0))
                  || ((state == WAIT) && (waitCnt == 4'd1));

  // Control FSM, registered handshake outputs and the single-edge commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            latWe     <= req_we;
            latSize   <= req_size;
            latAddr   <= req_addr;
            latWdata  <= req_wdata;
            waitCnt   <= 4'(WAIT_CYCLES);
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          waitCnt <= waitCnt - 4'd1;
          if (waitCnt == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase

      if (commitNow) begin
        rsp_rdata <= commitData;
        rsp_err   <= cErr;
        if (cWe && !cErr) mem[cIdx] <= mergedWord;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES = 2).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          lowCnt;

  dmem_responder #(.WAIT_CYCLES(2), .DEPTH(32), .ADDR_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // One complete transaction; lat = negedges after accept until rsp_valid (-1 on timeout).
  task automatic transact(input logic we, input logic [1:0] size, input logic [6:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int latency, output int lowCycles);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = ~wdata; req_addr = addr ^ 7'h7F; req_size = ~size;
    latency = -1; lowCycles = 0; rdata = 32'h0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin latency = i; break; end
      if (!req_ready) lowCycles++;
    end
    rdata = rsp_rdata; err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got=%h exp=00000000", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
  endtask

  task automatic test_preload();
    transact(1'b1, 2'b10, 7'h0C, 32'h11223344, rd, er, lat, lowCnt);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL preload_w3 got=%h exp=11223344", rd); end
    transact(1'b1, 2'b10, 7'h10, 32'h00000000, rd, er, lat, lowCnt);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL preload_w4 got=%h exp=00000000", rd); end
    transact(1'b1, 2'b10, 7'h00, 32'hCAFEF00D, rd, er, lat, lowCnt);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL preload_w0 got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_load_latency();
    transact(1'b0, 2'b10, 7'h0C, 32'hFFFFFFFF, rd, er, lat, lowCnt);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL load_rdata got=%h exp=11223344", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err got=%b exp=0", er); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency got=%0d exp=3", lat); end
    checks++; if (lowCnt !== 2) begin errors++; $display("FAIL load_ready_low got=%0d exp=2", lowCnt); end
  endtask

  task automatic test_byte_store();
    transact(1'b1, 2'b00, 7'h0E, 32'h000000AB, rd, er, lat, lowCnt);
    checks++; if (rd !== 32'h11AB3344) begin errors++; $display("FAIL byte_store_rdata got=%h exp=11ab3344", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL byte_store_err got=%b exp=0", er); end
    transact(1'b0, 2'b10, 7'h0C, 32'h0, rd, er, lat, lowCnt);
    checks++; if (rd !== 32'h11AB3344) begin errors++; $display("FAIL byte_store_readback got=%h exp=11ab3344", rd); end
  endtask

  task automatic test_half_store();
    transact(1'b1, 2'b01, 7'h12, 32'h1234BEEF, rd, er, lat, lowCnt);
    checks++; if (rd !== 32'hBEEF0000) begin errors++; $display("FAIL half_store_rdata got=%h exp=beef0000", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL half_store_err got=%b exp=0", er); end
    transact(1'b1, 2'b01, 7'h11, 32'h00005555, rd, er, lat, lowCnt);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL half_misalign_err got=%b exp=1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL half_misalign_rdata got=%h exp=00000000", rd); end
    transact(1'b0, 2'b10, 7'h10, 32'h0, rd, er, lat, lowCnt);
    checks++; if (rd !== 32'hBEEF0000) begin errors++; $display("FAIL half_readback got=%h exp=beef0000", rd); end
    transact(1'b1, 2'b00, 7'h11, 32'h00000077, rd, er, lat, lowCnt);
    checks++; if (rd !== 32'hBEEF7700) begin errors++; $display("FAIL byte_lane1 got=%h exp=beef7700", rd); end
  endtask

  task automatic test_errors();
    transact(1'b0, 2'b10, 7'h02, 32'h0, rd, er, lat, lowCnt);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL word_misalign_err got=%b exp=1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL word_misalign_rdata got=%h exp=00000000", rd); end
    transact(1'b1, 2'b11, 7'h0C, 32'hFFFFFFFF, rd, er, lat, lowCnt);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL size11_err got=%b exp=1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL size11_rdata got=%h exp=00000000", rd); end
    transact(1'b0, 2'b10, 7'h0C, 32'h0, rd, er, lat, lowCnt);
    checks++; if (rd !== 32'h11AB3344) begin errors++; $display("FAIL size11_nowrite got=%h exp=11ab3344", rd); end
    transact(1'b0, 2'b10, 7'h00, 32'h0, rd, er, lat, lowCnt);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL misalign_nowrite got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_resp_hold();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 7'h0C; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL hold_timeout got=%b exp=1", seen); end
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 7'h0C; req_wdata = 32'h55555555;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, rsp_valid); end
      checks++; if (rsp_rdata !== 32'h11AB3344) begin errors++; $display("FAIL hold_rdata cyc=%0d got=%h exp=11ab3344", i, rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL hold_err cyc=%0d got=%b exp=0", i, rsp_err); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_req_ready cyc=%0d got=%b exp=0", i, req_ready); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got=%b exp=0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got=%b exp=1", req_ready); end
    transact(1'b0, 2'b10, 7'h0C, 32'h0, rd, er, lat, lowCnt);
    checks++; if (rd !== 32'h11AB3344) begin errors++; $display("FAIL hold_ignored_store got=%h exp=11ab3344", rd); end
  endtask

  task automatic test_reset_wait();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 7'h00; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wait_rst_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wait_rst_valid got=%b exp=0", rsp_valid); end
    repeat (3) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wait_rst_no_rsp got=%b exp=0", rsp_valid); end
    transact(1'b0, 2'b10, 7'h00, 32'h0, rd, er, lat, lowCnt);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL wait_rst_nowrite got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_reset_vs_request();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 7'h10; req_wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b exp=0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    transact(1'b0, 2'b10, 7'h10, 32'h0, rd, er, lat, lowCnt);
    checks++; if (rd !== 32'hBEEF7700) begin errors++; $display("FAIL rst_req_nowrite got=%h exp=beef7700", rd); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_addr = 7'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    test_reset();
    test_preload();
    test_load_latency();
    test_byte_store();
    test_half_store();
    test_errors();
    test_resp_hold();
    test_reset_wait();
    test_reset_vs_request();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
